// File: rtl/dmc_req_sequencer.sv
// Request sequencer for the dmc: queues client read/write commands in a FIFO and
// issues them one at a time, holding read responses until the consumer takes them.
module dmc_req_sequencer #(
  parameter int DEPTH  = 4,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic                     req_sel,
  input  logic [7:0]               req_addr,
  input  logic [7:0]               req_wdata,
  output logic                     mem_select,
  output logic                     write_enable,
  output logic [7:0]               add_ex,
  output logic [7:0]               data_ex,
  input  logic [7:0]               data_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [7:0]               rsp_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(RD_LAT + 1);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q;
  logic [17:0]     fifo_mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [CW-1:0]   lat_q;
  logic            mem_select_q, write_enable_q, rsp_valid_q;
  logic [7:0]      add_ex_q, data_ex_q, rsp_data_q;
  logic            push, pop;
  logic [17:0]     head;

  assign req_ready = (count_q != FULL_COUNT);
  assign push      = req_valid && req_ready;
  assign pop       = (state_q == IDLE) && (count_q != '0);
  assign head      = fifo_mem[rd_ptr_q];

  // Entry layout: {we, sel, addr[7:0], wdata[7:0]}
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {req_we, req_sel, req_addr, req_wdata};
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + (AW + 1)'(1);
    else if (pop && !push) count_d = count_q - (AW + 1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      lat_q          <= '0;
      mem_select_q   <= 1'b0;
      write_enable_q <= 1'b0;
      add_ex_q       <= 8'h00;
      data_ex_q      <= 8'h00;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            {write_enable_q, mem_select_q, add_ex_q, data_ex_q} <= head;
            state_q <= ISSUE;
          end else begin
            write_enable_q <= 1'b0;
          end
        end
        ISSUE: begin
          if (write_enable_q) begin
            write_enable_q <= 1'b0;
            state_q        <= IDLE;
          end else begin
            lat_q   <= CW'(RD_LAT);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          lat_q <= lat_q - CW'(1);
          // Counter hits zero on this edge: data_out is valid now.
          if (lat_q == CW'(1)) begin
            rsp_data_q  <= data_out;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_select   = mem_select_q;
  assign write_enable = write_enable_q;
  assign add_ex       = add_ex_q;
  assign data_ex      = data_ex_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign fifo_count   = count_q;
  assign busy         = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_dmc_req_sequencer.sv
// Directed bench for dmc_req_sequencer: RD_LAT=1 instance against a small dmc
// memory model, plus an RD_LAT=3 instance with hand-driven data_out.
module tb_dmc_req_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       req_valid = 1'b0, req_we = 1'b0, req_sel = 1'b0, rsp_ready = 1'b1;
  logic [7:0] req_addr = 8'h00, req_wdata = 8'h00;
  logic       req_ready, mem_select, write_enable, rsp_valid, busy;
  logic [7:0] add_ex, data_ex, data_out, rsp_data;
  logic [2:0] fifo_count;

  logic       req_valid3 = 1'b0, req_we3 = 1'b0, req_sel3 = 1'b0, rsp_ready3 = 1'b1;
  logic [7:0] req_addr3 = 8'h00, req_wdata3 = 8'h00, data_out3 = 8'h00;
  logic       req_ready3, mem_select3, write_enable3, rsp_valid3, busy3;
  logic [7:0] add_ex3, data_ex3, rsp_data3;
  logic [2:0] fifo_count3;

  int checks = 0;
  int errors = 0;

  dmc_req_sequencer #(.DEPTH(4), .RD_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_sel(req_sel), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_select(mem_select), .write_enable(write_enable), .add_ex(add_ex),
    .data_ex(data_ex), .data_out(data_out), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .fifo_count(fifo_count), .busy(busy)
  );

  dmc_req_sequencer #(.DEPTH(4), .RD_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_we(req_we3), .req_sel(req_sel3), .req_addr(req_addr3), .req_wdata(req_wdata3),
    .mem_select(mem_select3), .write_enable(write_enable3), .add_ex(add_ex3),
    .data_ex(data_ex3), .data_out(data_out3), .rsp_valid(rsp_valid3),
    .rsp_ready(rsp_ready3), .rsp_data(rsp_data3), .fifo_count(fifo_count3), .busy(busy3)
  );

  // dmc model: two 256x8 memories, combinational read
  logic [7:0] mem_a [256] = '{3: 8'h5C, default: 8'h00};
  logic [7:0] mem_b [256] = '{default: 8'h00};
  always @(posedge clk) begin
    if (write_enable) begin
      if (mem_select) mem_b[add_ex] <= data_ex;
      else            mem_a[add_ex] <= data_ex;
    end
  end
  assign data_out = mem_select ? mem_b[add_ex] : mem_a[add_ex];

  // Transaction log: {we, sel, addr, data} per write strobe cycle / response
  logic [17:0] evlog[$];
  logic        rsp_prev = 1'b0;
  always @(negedge clk) begin
    if (write_enable) begin
      evlog.push_back({1'b1, mem_select, add_ex, data_ex});
      $display("[%0t] write sel=%0d addr=%02h data=%02h", $time, mem_select, add_ex, data_ex);
    end
    if (rsp_valid && !rsp_prev) begin
      evlog.push_back({1'b0, mem_select, add_ex, rsp_data});
      $display("[%0t] read  sel=%0d addr=%02h data=%02h", $time, mem_select, add_ex, rsp_data);
    end
    rsp_prev = rsp_valid;
  end

  task automatic push(input logic we, input logic sel, input logic [7:0] addr,
                      input logic [7:0] wdata, output logic ok);
    logic acc;
    req_we = we; req_sel = sel; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      acc = req_ready;
      @(negedge clk);
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_log(input int n, output logic ok);
    for (int i = 0; i < 100; i++) begin
      if (evlog.size() >= n) break;
      @(negedge clk);
    end
    @(negedge clk);
    ok = (evlog.size() >= n);
  endtask

  task automatic test_reset;
    #1;
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", write_enable); end
    checks++; if (mem_select !== 1'b0) begin errors++; $display("FAIL reset_sel got=%b exp=0", mem_select); end
    checks++; if (add_ex !== 8'h00) begin errors++; $display("FAIL reset_addr got=%02h exp=00", add_ex); end
    checks++; if (data_ex !== 8'h00) begin errors++; $display("FAIL reset_data got=%02h exp=00", data_ex); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rspv got=%b exp=0", rsp_valid); end
    checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rspd got=%02h exp=00", rsp_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    checks++; if (req_ready3 !== 1'b1) begin errors++; $display("FAIL reset_ready3 got=%b exp=1", req_ready3); end
  endtask

  task automatic test_write_read;
    logic ok;
    int base;
    base = evlog.size();
    push(1'b1, 1'b0, 8'h02, 8'h0A, ok);
    push(1'b0, 1'b0, 8'h02, 8'h00, ok);
    wait_log(base + 2, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wr_rd_timeout got=%0d exp=%0d events", evlog.size() - base, 2); end
    checks++; if (evlog[base] !== {1'b1, 1'b0, 8'h02, 8'h0A}) begin errors++; $display("FAIL wr_rd_write got=%05h exp=%05h", evlog[base], {1'b1, 1'b0, 8'h02, 8'h0A}); end
    checks++; if (evlog[base+1] !== {1'b0, 1'b0, 8'h02, 8'h0A}) begin errors++; $display("FAIL wr_rd_read got=%05h exp=%05h", evlog[base+1], {1'b0, 1'b0, 8'h02, 8'h0A}); end
    checks++; if (evlog.size() !== base + 2) begin errors++; $display("FAIL wr_rd_evcount got=%0d exp=2", evlog.size() - base); end
  endtask

  task automatic test_order;
    logic ok;
    int base;
    base = evlog.size();
    push(1'b1, 1'b1, 8'h03, 8'h0B, ok);
    push(1'b0, 1'b0, 8'h03, 8'h00, ok);
    push(1'b0, 1'b1, 8'h03, 8'h00, ok);
    wait_log(base + 3, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL order_timeout got=%0d exp=3 events", evlog.size() - base); end
    checks++; if (evlog[base] !== {1'b1, 1'b1, 8'h03, 8'h0B}) begin errors++; $display("FAIL order_w got=%05h exp=%05h", evlog[base], {1'b1, 1'b1, 8'h03, 8'h0B}); end
    checks++; if (evlog[base+1] !== {1'b0, 1'b0, 8'h03, 8'h5C}) begin errors++; $display("FAIL order_ra got=%05h exp=%05h", evlog[base+1], {1'b0, 1'b0, 8'h03, 8'h5C}); end
    checks++; if (evlog[base+2] !== {1'b0, 1'b1, 8'h03, 8'h0B}) begin errors++; $display("FAIL order_rb got=%05h exp=%05h", evlog[base+2], {1'b0, 1'b1, 8'h03, 8'h0B}); end
  endtask

  task automatic test_back_to_back;
    logic ok;
    int base;
    base = evlog.size();
    rsp_ready = 1'b0;
    push(1'b0, 1'b0, 8'h02, 8'h00, ok);
    wait_log(base + 1, ok);
    push(1'b1, 1'b0, 8'h05, 8'h55, ok);
    push(1'b1, 1'b1, 8'h06, 8'h66, ok);
    push(1'b0, 1'b0, 8'h05, 8'h00, ok);
    push(1'b0, 1'b1, 8'h06, 8'h00, ok);
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL b2b_full_count got=%0d exp=4", fifo_count); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got=%b exp=0", req_ready); end
    req_we = 1'b1; req_sel = 1'b0; req_addr = 8'h07; req_wdata = 8'h77; req_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL b2b_held_count got=%0d exp=4", fifo_count); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got=%b exp=1", busy); end
    rsp_ready = 1'b1;
    push(1'b1, 1'b0, 8'h07, 8'h77, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_fifth_accept got=%b exp=1", ok); end
    wait_log(base + 6, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_timeout got=%0d exp=6 events", evlog.size() - base); end
    checks++; if (evlog[base]   !== {1'b0, 1'b0, 8'h02, 8'h0A}) begin errors++; $display("FAIL b2b_ev0 got=%05h exp=%05h", evlog[base],   {1'b0, 1'b0, 8'h02, 8'h0A}); end
    checks++; if (evlog[base+1] !== {1'b1, 1'b0, 8'h05, 8'h55}) begin errors++; $display("FAIL b2b_ev1 got=%05h exp=%05h", evlog[base+1], {1'b1, 1'b0, 8'h05, 8'h55}); end
    checks++; if (evlog[base+2] !== {1'b1, 1'b1, 8'h06, 8'h66}) begin errors++; $display("FAIL b2b_ev2 got=%05h exp=%05h", evlog[base+2], {1'b1, 1'b1, 8'h06, 8'h66}); end
    checks++; if (evlog[base+3] !== {1'b0, 1'b0, 8'h05, 8'h55}) begin errors++; $display("FAIL b2b_ev3 got=%05h exp=%05h", evlog[base+3], {1'b0, 1'b0, 8'h05, 8'h55}); end
    checks++; if (evlog[base+4] !== {1'b0, 1'b1, 8'h06, 8'h66}) begin errors++; $display("FAIL b2b_ev4 got=%05h exp=%05h", evlog[base+4], {1'b0, 1'b1, 8'h06, 8'h66}); end
    checks++; if (evlog[base+5] !== {1'b1, 1'b0, 8'h07, 8'h77}) begin errors++; $display("FAIL b2b_ev5 got=%05h exp=%05h", evlog[base+5], {1'b1, 1'b0, 8'h07, 8'h77}); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_rsp_hold;
    logic ok;
    int base;
    base = evlog.size();
    rsp_ready = 1'b0;
    push(1'b0, 1'b1, 8'h03, 8'h00, ok);
    wait_log(base + 1, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL hold_timeout got=%0d exp=1 events", evlog.size() - base); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL hold_rspv[%0d] got=%b exp=1", i, rsp_valid); end
      checks++; if (rsp_data !== 8'h0B) begin errors++; $display("FAIL hold_rspd[%0d] got=%02h exp=0b", i, rsp_data); end
      checks++; if ({mem_select, add_ex, write_enable} !== {1'b1, 8'h03, 1'b0}) begin errors++; $display("FAIL hold_dmc[%0d] got=%0d/%02h/%0d exp=1/03/0", i, mem_select, add_ex, write_enable); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL hold_release_rspv got=%b exp=0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_release_busy got=%b exp=0", busy); end
  endtask

  task automatic test_rd_lat3;
    @(negedge clk);
    req_we3 = 1'b0; req_sel3 = 1'b1; req_addr3 = 8'h44; req_wdata3 = 8'h00; req_valid3 = 1'b1;
    @(negedge clk);
    req_valid3 = 1'b0; data_out3 = 8'hA1;
    checks++; if (fifo_count3 !== 3'd1) begin errors++; $display("FAIL lat3_count got=%0d exp=1", fifo_count3); end
    @(negedge clk);
    data_out3 = 8'hA2;
    checks++; if ({mem_select3, add_ex3, write_enable3} !== {1'b1, 8'h44, 1'b0}) begin errors++; $display("FAIL lat3_issue got=%0d/%02h/%0d exp=1/44/0", mem_select3, add_ex3, write_enable3); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      data_out3 = 8'hA3 + 8'(i);
      checks++; if (add_ex3 !== 8'h44 || rsp_valid3 !== 1'b0) begin errors++; $display("FAIL lat3_wait[%0d] got=%02h/%0d exp=44/0", i, add_ex3, rsp_valid3); end
    end
    @(negedge clk);
    checks++; if (rsp_valid3 !== 1'b1) begin errors++; $display("FAIL lat3_rspv got=%b exp=1", rsp_valid3); end
    checks++; if (rsp_data3 !== 8'hA5) begin errors++; $display("FAIL lat3_rspd got=%02h exp=a5", rsp_data3); end
    @(negedge clk);
    checks++; if (rsp_valid3 !== 1'b0) begin errors++; $display("FAIL lat3_release got=%b exp=0", rsp_valid3); end
  endtask

  task automatic test_reset_wait;
    logic ok;
    int base;
    base = evlog.size();
    push(1'b0, 1'b1, 8'h03, 8'hEE, ok);
    push(1'b1, 1'b0, 8'h08, 8'h88, ok);
    push(1'b1, 1'b0, 8'h09, 8'h99, ok);
    checks++; if ({busy, rsp_valid, add_ex, fifo_count} !== {1'b1, 1'b0, 8'h03, 3'd2}) begin errors++; $display("FAIL rstw_pre got=%0d/%0d/%02h/%0d exp=1/0/03/2", busy, rsp_valid, add_ex, fifo_count); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({mem_select, write_enable, add_ex, data_ex} !== 18'h0) begin errors++; $display("FAIL rstw_dmc got=%0d/%0d/%02h/%02h exp=0/0/00/00", mem_select, write_enable, add_ex, data_ex); end
    checks++; if ({rsp_valid, rsp_data, busy, fifo_count} !== 13'h0) begin errors++; $display("FAIL rstw_rsp got=%0d/%02h/%0d/%0d exp=0/00/0/0", rsp_valid, rsp_data, busy, fifo_count); end
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (evlog.size() !== base) begin errors++; $display("FAIL rstw_no_events got=%0d exp=0", evlog.size() - base); end
    checks++; if ({fifo_count, busy, rsp_valid} !== 5'h0) begin errors++; $display("FAIL rstw_after got=%0d/%0d/%0d exp=0/0/0", fifo_count, busy, rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_order();
    test_back_to_back();
    test_rsp_hold();
    test_rd_lat3();
    test_reset_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
